// File: rtl/count_pkg.sv
// Shared definitions for the count monitor: default widths, FSM encoding and
// the saturating-increment rule used by the tally counters.
package count_pkg;

  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned WRAP_W_DEF = 8;
  localparam int unsigned ERR_W_DEF  = 8;
  localparam int unsigned LOCK_N_DEF = 4;
  localparam int unsigned MATCH_W    = 4;  // holds any LOCK_N in 1..15

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Next tally value: clear restarts at zero, increment stops at max (so clr+inc gives 1).
  function automatic logic [31:0] sat_next(input logic [31:0] q, input logic [31:0] max,
                                           input logic inc, input logic clr);
    logic [31:0] base;
    base = clr ? 32'd0 : q;
    if (inc && (base != max)) return base + 32'd1;
    return base;
  endfunction

endpackage

// File: rtl/count_monitor_if.sv
// Snapshot readout handshake between the monitor and the debug consumer.
interface count_monitor_if #(
  parameter int unsigned WRAP_W = count_pkg::WRAP_W_DEF,
  parameter int unsigned ERR_W  = count_pkg::ERR_W_DEF
);
  logic              snap_req;
  logic              snap_ready;
  logic              snap_valid;
  logic [WRAP_W-1:0] snap_wraps;
  logic [ERR_W-1:0]  snap_errs;

  modport slave (
    input  snap_req, snap_ready,
    output snap_valid, snap_wraps, snap_errs
  );

  modport master (
    output snap_req, snap_ready,
    input  snap_valid, snap_wraps, snap_errs
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating tally with synchronous clear; exposes the value it will hold after
// the coming edge so a capture in the same cycle sees the current event.
module sat_counter
  import count_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] nxt_c
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] q;

  assign nxt_c = W'(sat_next(32'(q), 32'(MAX), inc, clr));

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= nxt_c;
  end

endmodule

// File: rtl/count_monitor.sv
// Checks that a free-running count advances by +1 each clock, tallies wraps and
// sequence errors, and offers a snapshot of both tallies over valid/ready.
module count_monitor
  import count_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned WRAP_W      = WRAP_W_DEF,
  parameter int unsigned ERR_W       = ERR_W_DEF,
  parameter int unsigned LOCK_N      = LOCK_N_DEF,
  parameter bit          CLR_ON_SNAP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  count_monitor_if.slave   snap,
  output logic             locked,
  output logic             err_pulse
);

  state_t             state;
  logic [CNT_W-1:0]   prev;
  logic [MATCH_W-1:0] match;

  logic [CNT_W-1:0]   exp_c;
  logic               hit_c;
  logic               wrap_ev_c;
  logic               err_ev_c;
  logic               xfer_c;
  logic               clr_c;
  logic [WRAP_W-1:0]  wraps_nxt_c;
  logic [ERR_W-1:0]   errs_nxt_c;

  assign exp_c     = prev + CNT_W'(1);
  assign hit_c     = (cnt == exp_c);
  assign wrap_ev_c = en && (state == LOCKED) && (prev == '1) && (cnt == '0);
  assign err_ev_c  = en && (state == LOCKED) && !hit_c;
  assign xfer_c    = snap.snap_valid && snap.snap_ready;
  assign clr_c     = CLR_ON_SNAP && xfer_c;

  sat_counter #(.W(WRAP_W)) u_wraps (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_ev_c),
    .clr   (clr_c),
    .nxt_c (wraps_nxt_c)
  );

  sat_counter #(.W(ERR_W)) u_errs (
    .clk   (clk),
    .reset (reset),
    .inc   (err_ev_c),
    .clr   (clr_c),
    .nxt_c (errs_nxt_c)
  );

  // Sequence tracking FSM; dropping en parks it in IDLE from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= '0;
      match     <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_ev_c;
      if (!en) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        prev <= cnt;
        unique case (state)
          IDLE: begin
            match <= '0;
            state <= ACQ;
          end
          ACQ: begin
            if (hit_c) begin
              match <= match + MATCH_W'(1);
              if ((match + MATCH_W'(1)) == MATCH_W'(LOCK_N)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match <= '0;
            end
          end
          LOCKED: begin
            if (!hit_c) begin
              match  <= '0;
              state  <= ACQ;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Snapshot holder; a request landing on a transfer cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap.snap_valid <= 1'b0;
      snap.snap_wraps <= '0;
      snap.snap_errs  <= '0;
    end else if (xfer_c) begin
      snap.snap_valid <= 1'b0;
    end else if (!snap.snap_valid && snap.snap_req) begin
      snap.snap_valid <= 1'b1;
      snap.snap_wraps <= wraps_nxt_c;
      snap.snap_errs  <= errs_nxt_c;
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: directed scenarios plus a random run,
// all compared against a cycle-level behavioural model of the monitor.
`timescale 1ns/1ps
module tb_count_monitor;

  localparam int LOCK_N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] cnt;
  logic       locked;
  logic       err_pulse;
  logic [3:0] ctr;

  int checks = 0;
  int errors = 0;

  count_monitor_if #(.WRAP_W(8), .ERR_W(8)) snap ();

  count_monitor #(
    .CNT_W(4), .WRAP_W(8), .ERR_W(8), .LOCK_N(LOCK_N), .CLR_ON_SNAP(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cnt       (cnt),
    .snap      (snap),
    .locked    (locked),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integers, one update per rising edge.
  bit m_tracking, m_locked, m_ep, m_sv, m_wrap, m_err, m_xfer;
  int m_run, m_prev, m_wraps, m_errs, m_sw, m_se;

  always @(posedge clk) begin
    if (reset) begin
      m_tracking = 0; m_locked = 0; m_ep = 0; m_sv = 0;
      m_run = 0; m_prev = 0; m_wraps = 0; m_errs = 0; m_sw = 0; m_se = 0;
    end else begin
      m_wrap = 0;
      m_err  = 0;
      m_xfer = m_sv && (snap.snap_ready === 1'b1);
      if (en !== 1'b1) begin
        m_tracking = 0;
        m_locked   = 0;
      end else begin
        if (!m_tracking) begin
          m_tracking = 1;
          m_run      = 0;
        end else if (int'(cnt) == (m_prev + 1) % 16) begin
          if (m_locked && m_prev == 15) m_wrap = 1;
          if (!m_locked) begin
            m_run = m_run + 1;
            if (m_run == LOCK_N) m_locked = 1;
          end
        end else begin
          m_err    = m_locked;
          m_locked = 0;
          m_run    = 0;
        end
        m_prev = int'(cnt);
      end
      m_ep = m_err;
      if (m_xfer) begin m_wraps = 0; m_errs = 0; end
      if (m_wrap) m_wraps = (m_wraps >= 255) ? 255 : m_wraps + 1;
      if (m_err)  m_errs  = (m_errs  >= 255) ? 255 : m_errs + 1;
      if (m_xfer) m_sv = 0;
      else if (!m_sv && snap.snap_req === 1'b1) begin
        m_sv = 1; m_sw = m_wraps; m_se = m_errs;
      end
    end
  end

  logic [18:0] obs, mexp;
  assign obs  = {locked, err_pulse, snap.snap_valid,
                 snap.snap_valid ? {snap.snap_wraps, snap.snap_errs} : 16'h0};
  assign mexp = {m_locked, m_ep, m_sv, m_sv ? {8'(m_sw), 8'(m_se)} : 16'h0};

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; cnt = 4'd0; ctr = 4'd0;
    snap.snap_req = 1'b0; snap.snap_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 19'h0) begin errors++; $display("FAIL reset_hold: got %h want %h", obs, 19'h0); end
      cnt = 4'($urandom);
      snap.snap_req = 1'($urandom);
    end
    reset = 1'b0; snap.snap_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 19'h0 || mexp !== 19'h0) begin
        errors++; $display("FAIL idle_after_reset: got %h want %h", obs, 19'h0);
      end
      cnt = ~cnt;
    end
  endtask

  task automatic test_lock();
    int lock_at;
    lock_at = -1;
    ctr = 4'd0; cnt = ctr; en = 1'b1;
    for (int k = 1; k <= 53; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL lock_seq k=%0d: got %h want %h", k, obs, mexp); end
      if (locked === 1'b1 && lock_at < 0) lock_at = k;
      ctr++; cnt = ctr;
      if (k == 53) snap.snap_req = 1'b1;
    end
    checks++;
    if (lock_at != 5) begin errors++; $display("FAIL lock_latency: got %0d want 5", lock_at); end
    @(negedge clk);
    checks++;
    if (snap.snap_valid !== 1'b1 || snap.snap_wraps !== 8'd3 || snap.snap_errs !== 8'd0) begin
      errors++; $display("FAIL snap_wraps3: got v=%b w=%0d e=%0d want v=1 w=3 e=0",
                         snap.snap_valid, snap.snap_wraps, snap.snap_errs);
    end
    snap.snap_req = 1'b0; snap.snap_ready = 1'b1; ctr++; cnt = ctr;
    @(negedge clk);
    checks++;
    if (snap.snap_valid !== 1'b0 || obs !== mexp) begin
      errors++; $display("FAIL snap_drop: got %h want %h", obs, mexp);
    end
    snap.snap_ready = 1'b0; ctr++; cnt = ctr;
  endtask

  task automatic test_count_reset();
    bit found;
    int pulses;
    found = 0; pulses = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL pre_creset: got %h want %h", obs, mexp); end
      if (locked === 1'b1 && cnt == 4'd7) found = 1;
      else begin ctr++; cnt = ctr; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL creset_timeout: got found=0 want found=1"); end
    for (int k = 0; k < 12; k++) begin
      if (k < 3) cnt = 4'd0;
      else begin ctr = 4'(k - 2); cnt = ctr; end
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL creset_seq k=%0d: got %h want %h", k, obs, mexp); end
      if (err_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || locked !== 1'b1) begin
      errors++; $display("FAIL creset_pulses: got pulses=%0d locked=%b want pulses=1 locked=1", pulses, locked);
    end
    ctr++; cnt = ctr; snap.snap_req = 1'b1;
    @(negedge clk);
    checks++;
    if (snap.snap_valid !== 1'b1 || snap.snap_errs !== 8'd1 || obs !== mexp) begin
      errors++; $display("FAIL snap_errs1: got v=%b e=%0d want v=1 e=1", snap.snap_valid, snap.snap_errs);
    end
    snap.snap_req = 1'b0; snap.snap_ready = 1'b1; ctr++; cnt = ctr;
    @(negedge clk);
    snap.snap_ready = 1'b0; ctr++; cnt = ctr;
  endtask

  task automatic test_saturate();
    int forced;
    forced = 0;
    for (int b = 0; b < 5000 && forced < 300; b++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL sat_seq b=%0d: got %h want %h", b, obs, mexp); end
      ctr++;
      if (locked === 1'b1 && ctr != 4'd5) begin cnt = 4'd5; forced++; end
      else cnt = ctr;
    end
    checks++;
    if (forced != 300) begin errors++; $display("FAIL sat_timeout: got forced=%0d want 300", forced); end
    snap.snap_req = 1'b1;
    @(negedge clk);
    checks++;
    if (snap.snap_valid !== 1'b1 || snap.snap_errs !== 8'd255 || obs !== mexp) begin
      errors++; $display("FAIL errs_saturate: got v=%b e=%0d want v=1 e=255", snap.snap_valid, snap.snap_errs);
    end
    snap.snap_req = 1'b0; snap.snap_ready = 1'b1; ctr++; cnt = ctr;
    @(negedge clk);
    snap.snap_ready = 1'b0; ctr++; cnt = ctr;
  endtask

  task automatic test_snap_hold();
    bit found;
    found = 0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL pre_hold: got %h want %h", obs, mexp); end
      if (locked === 1'b1 && ctr == 4'd8) found = 1;
      else begin ctr++; cnt = ctr; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL hold_timeout: got found=0 want found=1"); end
    ctr++; cnt = ctr; snap.snap_req = 1'b1;
    for (int h = 0; h < 10; h++) begin
      @(negedge clk);
      checks++;
      if (snap.snap_valid !== 1'b1 || obs !== mexp) begin
        errors++; $display("FAIL snap_hold h=%0d: got %h want %h", h, obs, mexp);
      end
      snap.snap_req = (h == 4);
      ctr++; cnt = ctr;
    end
    snap.snap_ready = 1'b1;
    for (int q = 0; q < 4; q++) begin
      @(negedge clk);
      checks++;
      if (snap.snap_valid !== 1'b0 || obs !== mexp) begin
        errors++; $display("FAIL single_xfer q=%0d: got %h want %h", q, obs, mexp);
      end
      snap.snap_ready = 1'b0; snap.snap_req = 1'b0;
      ctr++; cnt = ctr;
    end
  endtask

  task automatic test_xfer_wrap();
    bit found;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL pre_xwrap: got %h want %h", obs, mexp); end
      if (locked === 1'b1 && ctr == 4'd12) found = 1;
      else begin ctr++; cnt = ctr; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL xwrap_timeout: got found=0 want found=1"); end
    ctr++; cnt = ctr; snap.snap_req = 1'b1;          // request on sample 13
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      snap.snap_req = 1'b0;
      ctr++; cnt = ctr;
      if (s == 2) snap.snap_ready = 1'b1;            // transfer on the 15->0 sample
    end
    @(negedge clk);
    snap.snap_ready = 1'b0; snap.snap_req = 1'b1; ctr++; cnt = ctr;
    @(negedge clk);
    checks++;
    if (snap.snap_valid !== 1'b1 || snap.snap_wraps !== 8'd1 || obs !== mexp) begin
      errors++; $display("FAIL xfer_wrap_keep1: got v=%b w=%0d want v=1 w=1", snap.snap_valid, snap.snap_wraps);
    end
    snap.snap_req = 1'b0; snap.snap_ready = 1'b1; ctr++; cnt = ctr;
    @(negedge clk);
    snap.snap_ready = 1'b0; snap.snap_req = 1'b1; ctr++; cnt = ctr;
    @(negedge clk);
    checks++;
    if (snap.snap_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", snap.snap_valid); end
    snap.snap_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 19'h0 || snap.snap_valid !== 1'b0) begin
      errors++; $display("FAIL reset_clears_snap: got %h want %h", obs, 19'h0);
    end
    reset = 1'b0; ctr++; cnt = ctr;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL random i=%0d: got %h want %h", i, obs, mexp); end
      en = ($urandom_range(0, 99) < 97);
      ctr++;
      if ($urandom_range(0, 99) < 2) ctr = 4'd0;
      cnt = ($urandom_range(0, 99) < 4) ? 4'($urandom) : ctr;
      snap.snap_req   = ($urandom_range(0, 9) == 0);
      snap.snap_ready = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_count_reset();
    test_saturate();
    test_snap_hold();
    test_xfer_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
